cordic_core_arbiter: RTL
========================

// Module: cordic_core_arbiter
// PURPOSE
//  Shares one iterative cosine CORDIC core (start/clk_en/done handshake, 16 iterations) between two requesters.
//  Grants requesters round-robin and latches the granted angle.
//  Sequences the core launch -> run -> freeze, captures the result and returns it with a one-cycle ack.
//  Sits between the custom-instruction front ends and the single CORDIC datapath instance.
// PARAMETERS
//  ITERATIONS   16   core iterations from start to done; used only for checking
//  TIMEOUT      31   max RUN cycles without core_done before abort; must be > ITERATIONS
//  CNT_W        5    width of RUN-cycle counter; must hold TIMEOUT
// PORTS
//  clock        in   1   system clock, all logic on rising edge
//  aclr         in   1   synchronous active-high reset
//  req0         in   1   requester 0 request, held high until ack0
//  angle0       in   32  requester 0 IEEE-754 single angle (radians), stable while req0
//  req1         in   1   requester 1 request, held high until ack1
//  angle1       in   32  requester 1 IEEE-754 single angle, stable while req1
//  ack0         out  1   one-cycle pulse: result0/err0 valid
//  ack1         out  1   one-cycle pulse: result1/err1 valid
//  result0      out  32  cosine result for requester 0, held until its next ack
//  result1      out  32  cosine result for requester 1, held until its next ack
//  err0         out  1   qualifies ack0: 1 = timeout abort, result0 forced to 0
//  err1         out  1   qualifies ack1: same meaning as err0, for requester 1
//  busy         out  1   high in any state other than IDLE
//  core_aclr    out  1   core reset = aclr OR abort pulse
//  core_clk_en  out  1   core clock enable
//  core_start   out  1   core load strobe
//  core_dataa   out  32  angle to core; registered at grant
//  core_done    in   1   core done; stays high while the core is frozen at index 16
//  core_result  in   32  core floating-point result; valid while core_done=1
// BEHAVIOUR
//  Reset (aclr=1 at edge):
//   - state=IDLE, rr_ptr=0, all outputs 0 except core_aclr=1.
//   - Reset mid-operation abandons the operation: no ack is issued.
//  FSM IDLE -> LAUNCH -> RUN -> RESPOND -> IDLE; ABORT is reached from RUN.
//  IDLE:
//   - If either req is high: grant sel (see arbitration), latch angle_sel into core_dataa, go to LAUNCH.
//  LAUNCH (1 cycle):
//   - core_start=1, core_clk_en=1; clear cnt; go to RUN.
//  RUN:
//   - core_start=0; core_clk_en = ~core_done (combinational), so the core freezes with done held.
//   - cnt increments each cycle.
//   - If core_done: latch core_result into result_sel, go to RESPOND.
//   - Else if cnt==TIMEOUT: go to ABORT.
//  RESPOND (1 cycle):
//   - ack_sel=1, err_sel=0; rr_ptr <= ~sel; go to IDLE.
//  ABORT (1 cycle):
//   - ack_sel=1, err_sel=1, result_sel=0, core_aclr=1; rr_ptr <= ~sel; go to IDLE.
//  Latency:
//   - req seen in IDLE at cycle T: LAUNCH T+1, done at T+18, ack at T+19.
//   - Back-to-back: next grant from IDLE at T+20.
//  Arbitration:
//   - Only one request pending: grant it.
//   - Both pending: grant rr_ptr, so a simultaneous pair alternates.
//  Request handling:
//   - A request dropped after grant still completes and is acked.
//   - A requester must not reassert req in its own ack cycle; the first new req is seen in IDLE the following cycle.
//  Outputs:
//   - ack0 and ack1 are never high together; at most one ack per grant.
//   - core_start is never high while core_clk_en is low.
//   - err is meaningful only while its ack is high.
// TESTING
//  1. aclr 2 cycles, then req0=1, angle0=0x00000000.
//     -> ack0 at T+19, err0=0, result0 ~0x3F800000 (cos 0, within 2^-18).
//  2. req0 & req1 rise in the same cycle, angle0=0x3F800000, angle1=0x3F000000.
//     -> ack0 first, ack1 exactly 20 cycles later; result1 ~0x3F60A940.
//     -> Repeat the pair: req1 is granted first.
//  3. Core model never asserts core_done.
//     -> ack0 & err0=1 at cnt=TIMEOUT+1, result0=0, core_aclr pulse 1 cycle, busy falls.
//  4. aclr asserted during RUN.
//     -> no ack; IDLE next cycle; a later req0 completes normally with correct result.
//  5. req1 dropped 3 cycles after grant.
//     -> ack1 still issued at T+19.
//  6. Check in every cycle: core_clk_en=0 while core_done=1 in RUN, and core_start=1 only in LAUNCH.

Source files
------------

// File: rtl/cordic_core_arbiter.sv
// Round-robin share of one iterative cosine CORDIC core between two requesters.
// Latency: ack 19 cycles after the grant cycle, and the next grant comes one cycle after the ack. Callers hold req until ack, so there is no backpressure.
module cordic_core_arbiter #(
    parameter int ITERATIONS = 16,
    parameter int TIMEOUT    = 31,
    parameter int CNT_W      = 5
) (
    input  logic        clock,
    input  logic        aclr,
    input  logic        req0,
    input  logic [31:0] angle0,
    input  logic        req1,
    input  logic [31:0] angle1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] result0,
    output logic [31:0] result1,
    output logic        err0,
    output logic        err1,
    output logic        busy,
    output logic        core_aclr,
    output logic        core_clk_en,
    output logic        core_start,
    output logic [31:0] core_dataa,
    input  logic        core_done,
    input  logic [31:0] core_result
);

    if (TIMEOUT <= ITERATIONS || TIMEOUT >= (1 << CNT_W)) begin : g_bad_params
        $error("cordic_core_arbiter: TIMEOUT must exceed ITERATIONS and fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        RUN,
        RESPOND,
        ABORT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             sel;
    logic             rr_ptr;
    logic             grant_sel;
    logic             abort_pulse;
    logic [CNT_W-1:0] cnt;

    // A lone request wins outright; a simultaneous pair goes to rr_ptr.
    assign grant_sel = (req0 && req1) ? rr_ptr : req1;

    always_ff @(posedge clock) begin
        if (aclr) begin
            state      <= IDLE;
            sel        <= 1'b0;
            rr_ptr     <= 1'b0;
            cnt        <= '0;
            core_dataa <= '0;
            result0    <= '0;
            result1    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        sel        <= grant_sel;
                        core_dataa <= grant_sel ? angle1 : angle0;
                    end
                end
                LAUNCH: cnt <= '0;
                RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    if (core_done) begin
                        if (sel) result1 <= core_result;
                        else     result0 <= core_result;
                    end else if (cnt == TIMEOUT_CNT) begin
                        if (sel) result1 <= '0;
                        else     result0 <= '0;
                    end
                end
                RESPOND, ABORT: rr_ptr <= ~sel;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt   = state;
        core_start  = 1'b0;
        core_clk_en = 1'b0;
        ack0        = 1'b0;
        ack1        = 1'b0;
        err0        = 1'b0;
        err1        = 1'b0;
        abort_pulse = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) state_nxt = LAUNCH;
            end
            LAUNCH: begin
                core_start  = 1'b1;
                core_clk_en = 1'b1;
                state_nxt   = RUN;
            end
            RUN: begin
                // Gating the enable on done freezes the core with its result held.
                core_clk_en = ~core_done;
                if (core_done)                state_nxt = RESPOND;
                else if (cnt == TIMEOUT_CNT)  state_nxt = ABORT;
            end
            RESPOND: begin
                ack0      = ~sel;
                ack1      = sel;
                state_nxt = IDLE;
            end
            ABORT: begin
                ack0        = ~sel;
                ack1        = sel;
                err0        = ~sel;
                err1        = sel;
                abort_pulse = 1'b1;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign core_aclr = aclr | abort_pulse;

endmodule
